// File: rtl/mdio_sequencer_pkg.sv
// rtl/mdio_sequencer_pkg.sv - shared constants, state encoding and frame builder for the MDIO sequencer
package mdio_pkg;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] ST    = 2'b01;

  localparam int TA_BIT0   = 46;
  localparam int TA_BIT1   = 47;
  localparam int DATA_BIT0 = 48;
  localparam int FRAME_LEN = 64;
  localparam int TAIL_LEN  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } seq_state_t;

  // Bit 63 goes out first; released read bits are filled with 1 so the line idles high.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic        wr,
    input logic [4:0]  phyad,
    input logic [4:0]  regad,
    input logic [15:0] wdata
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = wr ? OP_WR : OP_RD;
    ta   = wr ? 2'b10 : 2'b11;
    data = wr ? wdata : 16'hFFFF;
    return {32'hFFFF_FFFF, ST, op, phyad, regad, ta, data};
  endfunction

endpackage

// File: rtl/mdio_sequencer_if.sv
// rtl/mdio_sequencer_if.sv - requester-side request/completion bus of the MDIO sequencer
interface mdio_sequencer_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [5*NREQ-1:0]  req_phyad;
  logic [5*NREQ-1:0]  req_regad;
  logic [16*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [15:0]        rdata;
  logic               err;
  logic               busy;

  modport master (
    output req, req_wr, req_phyad, req_regad, req_wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, req_wr, req_phyad, req_regad, req_wdata,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/mdio_sequencer_frame_shifter.sv
// rtl/mdio_sequencer_frame_shifter.sv - MDC divider and 64-bit frame shifter; read capture only with MDIO_READ_EN
module mdio_frame_shifter
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MDIO_READ_EN
  input  logic                 is_read,
  input  logic                 mdio_in,
  output logic [15:0]          rdata,
  output logic                 ta_err,
`endif
  input  logic                 start,
  input  logic [FRAME_LEN-1:0] frame,
  output logic                 frame_end,
  output logic                 done,
  output logic                 mdc,
  output logic                 mdio_out,
  output logic                 mdio_oe
);

  localparam int              CW       = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0]   PRE_RISE = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(2 * MDC_DIV - 1);
  localparam logic [6:0]      LAST_BIT = 7'(FRAME_LEN + TAIL_LEN - 1);

  logic                 active;
  logic [CW-1:0]        div_cnt;
  logic [6:0]           bit_cnt;
  logic [FRAME_LEN-1:0] sreg;
  logic                 mdc_q;
  logic                 period_end;

  assign period_end = active && (div_cnt == LAST_CNT);
  assign frame_end  = period_end && (bit_cnt == 7'(FRAME_LEN - 1));
  assign done       = period_end && (bit_cnt == LAST_BIT);
  assign mdc        = mdc_q;
  assign mdio_out   = active ? sreg[FRAME_LEN-1] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '1;
      mdc_q   <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= frame;
      mdc_q   <= 1'b0;
    end else if (active) begin
      if (div_cnt == PRE_RISE) begin
        mdc_q <= 1'b1;
      end
      if (period_end) begin
        mdc_q   <= 1'b0;
        div_cnt <= '0;
        sreg    <= {sreg[FRAME_LEN-2:0], 1'b1};
        if (bit_cnt == LAST_BIT) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mdio_oe = active && (bit_cnt < 7'(FRAME_LEN));
`ifdef MDIO_READ_EN
    if (is_read && (bit_cnt >= 7'(TA_BIT0))) begin
      mdio_oe = 1'b0;
    end
`endif
  end

`ifdef MDIO_READ_EN
  // Sample in the cycle MDC is first high, mid-way through the bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      ta_err <= 1'b0;
    end else if (start) begin
      rdata  <= '0;
      ta_err <= 1'b0;
    end else if (active && is_read && (div_cnt == CW'(MDC_DIV))) begin
      if (bit_cnt == 7'(TA_BIT1)) begin
        ta_err <= mdio_in;
      end
      if ((bit_cnt >= 7'(DATA_BIT0)) && (bit_cnt < 7'(FRAME_LEN))) begin
        rdata <= {rdata[14:0], mdio_in};
      end
    end
  end
`endif

endmodule

// File: rtl/mdio_sequencer.sv
// rtl/mdio_sequencer.sv - round-robin Clause-22 MDIO master; reads need MDIO_READ_EN, else they complete with ERR
module mdio_sequencer
  import mdio_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MDC_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mdio_sequencer_if.slave   bus,
  output logic              mdc,
  output logic              mdio_out,
  output logic              mdio_oe,
  input  logic              mdio_in
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  seq_state_t           state;
  seq_state_t           next_state;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        winner;
  logic [GW-1:0]        cand;
  logic                 found;
  logic                 hold_off;
  logic                 sh_start;
  logic                 sh_frame_end;
  logic                 sh_done;
  logic                 cur_wr;
  logic [4:0]           cur_phyad;
  logic [4:0]           cur_regad;
  logic [15:0]          cur_wdata;
  logic [15:0]          rdata_q;
  logic                 err_q;
  logic [FRAME_LEN-1:0] frame;

`ifdef MDIO_READ_EN
  logic [15:0]          sh_rdata;
  logic                 sh_ta_err;
`else
  logic                 unused_mdio_in;
  assign unused_mdio_in = mdio_in;
`endif

  assign frame     = build_frame(cur_wr, cur_phyad, cur_regad, cur_wdata);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = last_grant;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // hold_off blanks every grant in the first IDLE cycle after DONE: it keeps the
  // acknowledged requester out and guarantees the back-to-back gap.
  always_comb begin
    next_state = state;
    sh_start   = 1'b0;
    bus.busy   = (state != S_IDLE);
    for (int i = 0; i < NREQ; i++) begin
      bus.ack[i] = (state == S_DONE) && (grant == GW'(i));
    end
    case (state)
      S_IDLE:  if (found && !hold_off) next_state = S_GRANT;
      S_GRANT: begin
`ifdef MDIO_READ_EN
        next_state = S_SHIFT;
        sh_start   = 1'b1;
`else
        if (cur_wr) begin
          next_state = S_SHIFT;
          sh_start   = 1'b1;
        end else begin
          next_state = S_DONE;
        end
`endif
      end
      S_SHIFT: if (sh_frame_end) next_state = S_TAIL;
      S_TAIL:  if (sh_done) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GW'(NREQ - 1);
      grant      <= GW'(NREQ - 1);
      hold_off   <= 1'b0;
      cur_wr     <= 1'b0;
      cur_phyad  <= '0;
      cur_regad  <= '0;
      cur_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      hold_off <= (state == S_DONE);
      if ((state == S_IDLE) && (next_state == S_GRANT)) begin
        grant      <= winner;
        last_grant <= winner;
        cur_wr     <= bus.req_wr[winner];
        cur_phyad  <= bus.req_phyad[int'(winner)*5 +: 5];
        cur_regad  <= bus.req_regad[int'(winner)*5 +: 5];
        cur_wdata  <= bus.req_wdata[int'(winner)*16 +: 16];
      end
      if (next_state == S_DONE) begin
        if (cur_wr) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
`ifdef MDIO_READ_EN
          rdata_q <= sh_rdata;
          err_q   <= sh_ta_err;
`else
          rdata_q <= '0;
          err_q   <= 1'b1;
`endif
        end
      end
    end
  end

  mdio_frame_shifter #(
    .MDC_DIV (MDC_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MDIO_READ_EN
    .is_read   (!cur_wr),
    .mdio_in   (mdio_in),
    .rdata     (sh_rdata),
    .ta_err    (sh_ta_err),
`endif
    .start     (sh_start),
    .frame     (frame),
    .frame_end (sh_frame_end),
    .done      (sh_done),
    .mdc       (mdc),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe)
  );

endmodule

// File: tb/tb_mdio_sequencer.sv
// tb/tb_mdio_sequencer.sv - scoreboard bench for mdio_sequencer (NREQ=2, MDC_DIV=4), covers both MDIO_READ_EN builds
module tb_mdio_sequencer;

  typedef struct {
    int          idx;
    logic [15:0] rdata;
    bit          chk_rdata;
    logic        err;
    bit          chk_stream;
    logic [63:0] frame;
    logic [63:0] oe;
    int          rises;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in = 1'b1;
  logic [63:0] phy_resp = '1;
  logic [63:0] stream = '0;
  logic [63:0] oe_cap = '0;
  logic        mdc_prev = 1'b0;
  int          rise_n = 0;
  int          fall_n = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  exp_t        e;

  mdio_sequencer_if #(.NREQ(2)) bus ();

  mdio_sequencer #(.NREQ(2), .MDC_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mdc      (mdc),
    .mdio_out (mdio_out),
    .mdio_oe  (mdio_oe),
    .mdio_in  (mdio_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [15:0] rd, input bit chk_rd, input logic er,
                          input bit chk_st, input logic [63:0] fr, input logic [63:0] oe, input int rises);
    exp_t x;
    x.idx = idx; x.rdata = rd; x.chk_rdata = chk_rd; x.err = er;
    x.chk_stream = chk_st; x.frame = fr; x.oe = oe; x.rises = rises;
    sb.push_back(x);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd);
    bus.req_wr[i] = wr;
    bus.req_phyad[i*5 +: 5] = pa;
    bus.req_regad[i*5 +: 5] = ra;
    bus.req_wdata[i*16 +: 16] = wd;
  endtask

  task automatic wait_ack(input int idx, input int limit, output int cnt, output int first_oe);
    cnt = 0;
    first_oe = -1;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (mdio_oe && first_oe < 0) first_oe = cnt;
      if (bus.ack[idx]) break;
      if (cnt >= limit) begin
        total++;
        bad++;
        $display("FAIL timeout_ack%0d: no ACK after %0d cycles, required within %0d", idx, cnt, limit);
        break;
      end
    end
  endtask

  task automatic requester(input int i);
    int c, fo;
    for (int n = 0; n < 2; n++) begin
      bus.req[i] = 1'b1;
      wait_ack(i, 3000, c, fo);
      bus.req[i] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_mdc"}, mdc, 0);
    check({tag, "_mdio_out"}, mdio_out, 1);
    check({tag, "_mdio_oe"}, mdio_oe, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  // Monitor + PHY model: records the serial frame on MDC rise, drives MDIO_IN on MDC fall.
  always @(negedge clk) begin
    if (!rst_n) begin
      rise_n = 0; fall_n = 0; mdc_prev = 1'b0; mdio_in = 1'b1; stream = '0; oe_cap = '0;
    end else begin
      if (!bus.busy) begin
        rise_n = 0; fall_n = 0; mdio_in = 1'b1; stream = '0; oe_cap = '0;
      end
      if (mdc && !mdc_prev) begin
        if (rise_n < 64) begin
          stream[63-rise_n] = mdio_out;
          oe_cap[63-rise_n] = mdio_oe;
        end
        rise_n++;
      end
      if (!mdc && mdc_prev) begin
        fall_n++;
        mdio_in = (fall_n < 64) ? phy_resp[63-fall_n] : 1'b1;
      end
      mdc_prev = mdc;
      if (bus.ack != 0) begin
        check("ack_onehot", $countones(bus.ack), 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=%b required none", bus.ack);
        end else begin
          e = sb.pop_front();
          check("ack_idx", bus.ack, 64'd1 << e.idx);
          check("ack_err", bus.err, e.err);
          check("mdc_rises", rise_n, e.rises);
          if (e.chk_rdata) check("ack_rdata", bus.rdata, e.rdata);
          if (e.chk_stream) begin
            check("frame_oe", oe_cap, e.oe);
            check("frame_bits", stream & e.oe, e.frame & e.oe);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, fo, guard;
    bus.req = '0; bus.req_wr = '0; bus.req_phyad = '0; bus.req_regad = '0; bus.req_wdata = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write from requester 0.
    set_req(0, 1'b1, 5'h01, 5'h00, 16'h1140);
    push_exp(0, 16'h0, 0, 1'b0, 1, 64'hFFFFFFFF_50821140, '1, 65);
    bus.req[0] = 1'b1;
    wait_ack(0, 2000, cnt, fo);
    bus.req[0] = 1'b0;
    check("wr_ack_latency", cnt, 522);
    check("wr_t0", fo, 2);
    repeat (5) @(negedge clk);

`ifdef MDIO_READ_EN
    phy_resp = {{46{1'b1}}, 2'b10, 16'h796D};
    set_req(0, 1'b0, 5'h03, 5'h02, 16'h0);
    push_exp(0, 16'h796D, 1, 1'b0, 1, 64'hFFFFFFFF_618BFFFF, 64'hFFFFFFFF_FFFC0000, 65);
    bus.req[0] = 1'b1;
    wait_ack(0, 2000, cnt, fo);
    bus.req[0] = 1'b0;
    check("rd_ack_latency", cnt, 522);
    repeat (5) @(negedge clk);

    phy_resp = '1;
    set_req(1, 1'b0, 5'h03, 5'h02, 16'h0);
    push_exp(1, 16'hFFFF, 1, 1'b1, 1, 64'hFFFFFFFF_618BFFFF, 64'hFFFFFFFF_FFFC0000, 65);
    bus.req[1] = 1'b1;
    wait_ack(1, 2000, cnt, fo);
    bus.req[1] = 1'b0;
    check("rd_noresp_latency", cnt, 522);
`else
    set_req(1, 1'b0, 5'h03, 5'h02, 16'h0);
    push_exp(1, 16'h0, 1, 1'b1, 0, '0, '0, 0);
    bus.req[1] = 1'b1;
    wait_ack(1, 100, cnt, fo);
    bus.req[1] = 1'b0;
    check("rd_skip_latency", cnt, 2);
    check("rd_skip_no_oe", fo, -1);
`endif
    repeat (5) @(negedge clk);

    // Both requesters raised together and re-raised: grants must alternate 0,1,0,1.
    set_req(0, 1'b1, 5'h10, 5'h04, 16'h0001);
    set_req(1, 1'b1, 5'h1F, 5'h1F, 16'hA5A5);
    for (int n = 0; n < 2; n++) begin
      push_exp(0, 16'h0, 0, 1'b0, 1, 64'hFFFFFFFF_58120001, '1, 65);
      push_exp(1, 16'h0, 0, 1'b0, 1, 64'hFFFFFFFF_5FFEA5A5, '1, 65);
    end
    fork
      requester(0);
      requester(1);
    join
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame, then requester 0 must win first again.
    set_req(0, 1'b1, 5'h01, 5'h00, 16'h1140);
    bus.req[0] = 1'b1;
    guard = 0;
    while (rise_n < 21 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_bit20", (rise_n >= 21), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_busy_held", bus.busy, 0);
    push_exp(0, 16'h0, 0, 1'b0, 1, 64'hFFFFFFFF_50821140, '1, 65);
    rst_n = 1'b1;
    wait_ack(0, 2000, cnt, fo);
    bus.req = '0;
    check("post_reset_latency", cnt, 522);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_sequencer.md
# mdio_sequencer

Shared MDIO management master that serialises Clause-22 register transactions from several requesters onto one PHY management bus (MDC/MDIO). It sits between the configuration logic (PHY init, link-status pollers, slow-control register bridge) and the PHY or PCS/PMA management port. It generates MDC, drives and tri-state-controls MDIO, and samples read data. A round-robin arbiter grants one requester per frame and returns completion, read data and an error flag.

## Interface
- NREQ, 2: number of requesters, 1..8.
- MDC_DIV, 64: MDC half-period in CLK cycles, ≥2. Default gives MDC = CLK/128.
- CLK  in  1  system clock (125 MHz).
- RSTn  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester transaction request; level, held until ACK.
- REQ_WR  in  NREQ  1 = write, 0 = read.
- REQ_PHYAD  in  5*NREQ  PHY address; requester i uses bits [5i+4:5i].
- REQ_REGAD  in  5*NREQ  register address, same packing.
- REQ_WDATA  in  16*NREQ  write data; requester i uses bits [16i+15:16i].
- ACK  out  NREQ  one-cycle completion pulse to the granted requester.
- RDATA  out  16  read data; valid in the ACK cycle, held until the next ACK.
- ERR  out  1  valid with ACK. 1 = read saw no PHY response, or read unsupported.
- BUSY  out  1  high from grant through the ACK cycle.
- MDC  out  1  management clock.
- MDIO_OUT  out  1  serial data out.
- MDIO_OE  out  1  output enable for the MDIO pad.
- MDIO_IN  in  1  serial data in, already synchronised by the pad logic.

## Operation
- States: IDLE → GRANT → SHIFT → TAIL → DONE → IDLE.
- IDLE
  - MDC low, MDIO_OE 0, MDIO_OUT 1.
  - If any REQ is eligible: latch the winner's WR/PHYAD/REGAD/WDATA and go to GRANT.
- Arbitration: round-robin. Search starts at last_grant+1 modulo NREQ. last_grant resets to NREQ-1, so requester 0 wins first.
- GRANT: load the 64-bit frame, then go to SHIFT. Frame bits, in transmit order:
  - 32×'1' preamble
  - start '01'
  - op: '01' write, '10' read
  - PHYAD[4:0], MSB first
  - REGAD[4:0], MSB first
  - TA: '10' on write; released on read
  - 16 data bits, MSB first
- SHIFT: 64 MDC periods, one frame bit per period.
  - Write: MDIO_OE = 1 for all 64 bits.
  - Read: MDIO_OE = 1 for bits 0..45 and 0 for bits 46..63.
  - Read: bit 47 (second TA bit) is sampled. A sampled '1' sets ERR.
  - Read: bits 48..63 are shifted into RDATA, MSB first.
- TAIL: one further MDC period with MDIO_OE = 0 and MDC toggling, then DONE.
- DONE (one cycle):
  - ACK[grant] = 1; RDATA and ERR updated; BUSY still 1.
  - Then IDLE, with BUSY 0.
- The just-acknowledged requester is ineligible in the first IDLE cycle after DONE. A requester must drop REQ the cycle after ACK; a REQ still high after that cycle starts a new transaction.
- REQ deasserted mid-frame: the frame completes and ACK still pulses. REQ changes on non-granted requesters have no effect until IDLE.
- Inputs of the granted requester are latched at grant and never re-sampled.
- Reset (RSTn low, at any time, including mid-frame):
  - MDC 0, MDIO_OUT 1, MDIO_OE 0, ACK 0, RDATA 0, ERR 0, BUSY 0.
  - State IDLE; last_grant = NREQ-1.
  - No partial ACK is ever produced.

## Timing
- T0 = the first SHIFT cycle, which is 2 cycles after the IDLE cycle that saw REQ.
- Frame bit k is presented on MDIO_OUT/MDIO_OE at T0 + 2·MDC_DIV·k, together with MDC falling (MDC low).
- MDC rises at T0 + 2·MDC_DIV·k + MDC_DIV. MDIO_IN is sampled in that same cycle.
- TAIL occupies T0+128·MDC_DIV .. T0+130·MDC_DIV−1.
- ACK at T0 + 130·MDC_DIV.
- Default MDC_DIV = 64: ACK is 8320 cycles after T0, and 8322 cycles after the REQ-seen cycle.
- Back-to-back transactions: the next T0 is at least 4 cycles after the previous ACK.

## Configuration
- MDIO_READ_EN defined: read transactions behave as described above.
- MDIO_READ_EN undefined:
  - A read request is granted normally but skips SHIFT and TAIL: GRANT → DONE.
  - ACK is 1 cycle after GRANT, with ERR = 1 and RDATA = 0.
  - No MDC or MDIO activity; the MDIO_IN sampling logic is removed.
  - Writes are unchanged.

## Structure
- Package mdio_pkg holds:
  - opcode constants (OP_WR = 2'b01, OP_RD = 2'b10, ST = 2'b01)
  - state encoding
  - frame bit indices: TA_BIT0 = 46, TA_BIT1 = 47, DATA_BIT0 = 48, FRAME_LEN = 64, TAIL_LEN = 1
- Sub-module mdio_frame_shifter: MDC divider, 64-bit shift register, bit counter, OE control and read-data capture. It has a load/start input and a done output.
- The top level holds the arbiter, request latching and the ACK/RDATA/ERR registers.

## Test plan
- Single write, NREQ=2, MDC_DIV=4: requester 0 writes PHYAD=5'h1, REGAD=5'h0, WDATA=16'h1140.
  - Serial stream = 32×1, 0101, 00001, 00000, 10, 0001000101000000.
  - MDIO_OE = 1 throughout the 64 bits; ACK[0] at T0+520; ERR = 0.
- Read with PHY model returning TA = 0 and data 16'h796D (MDIO_READ_EN defined):
  - MDIO_OE drops at bit 46; RDATA = 16'h796D; ERR = 0.
- Read with MDIO_IN tied to 1: RDATA = 16'hFFFF, ERR = 1.
- REQ[0] and REQ[1] raised in the same cycle and held re-asserted:
  - Grants alternate 0,1,0,1.
  - Exactly one ACK per frame, never both bits set.
- RSTn pulsed low mid-frame at bit 20:
  - All outputs immediately take their reset values; no ACK.
  - After release, requester 0 is granted first.
- Read request with MDIO_READ_EN undefined:
  - ACK 1 cycle after GRANT, ERR = 1, RDATA = 0, MDC stays 0.
